// File: rtl/glitchless_mux_ctrl_if.sv
// -----------------------------------------------------------------------------
// glitchless_mux_ctrl_if
//
// Purpose:
//   Request handshake between a clock-switch requester and the
//   glitchless_mux_ctrl sequencer. A request transfers on a rising edge of the
//   controller clock where req_valid && req_ready.
//
// Signals:
//   req_valid  requester -> controller  switch request valid
//   req_sel    requester -> controller  requested clock (0 = clk1, 1 = clk2)
//   req_ready  controller -> requester  controller can accept a request
//
// Modports:
//   master  requester side (drives req_valid / req_sel)
//   slave   controller side (drives req_ready)
// -----------------------------------------------------------------------------
interface glitchless_mux_ctrl_if;

    logic req_valid;
    logic req_sel;
    logic req_ready;

    modport master (
        output req_valid,
        output req_sel,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_sel,
        output req_ready
    );

endinterface : glitchless_mux_ctrl_if

// File: rtl/glitchless_mux_ctrl.sv
// -----------------------------------------------------------------------------
// glitchless_mux_ctrl
//
// Purpose:
//   Switch sequencer for a 2:1 glitch-free clock mux. Runs on an always-on
//   reference clock, accepts switch requests over a valid/ready handshake,
//   refuses to switch to a clock reported dead, and after changing the mux
//   select waits SETTLE_CYCLES reference cycles (enough for the mux's
//   two-stage synchronisers in both clock domains) before reporting completion.
//
// Parameters:
//   SETTLE_CYCLES  clk cycles from a select change to done (>= 2)
//   CNT_W          settle counter width (derived, do not override)
//
// Ports:
//   clk        in   reference clock, always running
//   rst        in   asynchronous active-high reset
//   req_if     slave modport: req_valid / req_sel in, req_ready out
//   tgt_alive  in   per-clock liveness, bit0 = clk1, bit1 = clk2 (clk domain)
//   sel        out  select to the mux
//   cur_sel    out  last completed selection
//   busy       out  switch in progress
//   done       out  one-cycle pulse: switch completed or no-op accepted
//   err        out  one-cycle pulse: request rejected or switch aborted
// -----------------------------------------------------------------------------
module glitchless_mux_ctrl #(
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    glitchless_mux_ctrl_if.slave        req_if,
    input  logic [1:0]                  tgt_alive,
    output logic                        sel,
    output logic                        cur_sel,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SWITCH = 1'b1
    } state_t;

    // Counter reload value: the completing edge is the one that sees cnt==0,
    // so loading SETTLE_CYCLES-1 gives exactly SETTLE_CYCLES busy cycles.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // Registered state
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sel_r;
    logic             cur_sel_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;

    // Next-state values
    state_t           state_s;
    logic [CNT_W-1:0] cnt_s;
    logic             sel_s;
    logic             cur_sel_s;
    logic             busy_s;
    logic             done_s;
    logic             err_s;
    logic             accept_s;

    // Handshake: ready only while idle; acceptance is the valid/ready overlap.
    always_comb begin
        req_if.req_ready = (state_r == ST_IDLE);
        accept_s         = req_if.req_valid && (state_r == ST_IDLE);
    end

    // Next-state and next-output decode for the switch sequencer.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        sel_s     = sel_r;
        cur_sel_s = cur_sel_r;
        done_s    = 1'b0;
        err_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (req_if.req_sel == cur_sel_r) begin
                        // Already on the requested clock: acknowledge, no change.
                        done_s = 1'b1;
                    end else if (!tgt_alive[req_if.req_sel]) begin
                        // Never hand the mux to a clock that is not running.
                        err_s = 1'b1;
                    end else begin
                        sel_s   = req_if.req_sel;
                        cnt_s   = CNT_LOAD;
                        state_s = ST_SWITCH;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_SWITCH: begin
                if (!tgt_alive[sel_r]) begin
                    // Target died mid-handover: fall back to the source clock,
                    // which the mux still owns or can reclaim glitch-free.
                    sel_s   = cur_sel_r;
                    cnt_s   = CNT_ZERO;
                    err_s   = 1'b1;
                    state_s = ST_IDLE;
                end else if (cnt_r == CNT_ZERO) begin
                    cur_sel_s = sel_r;
                    done_s    = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            default: begin
                // Unreachable encoding: return to a known-safe idle state.
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                sel_s   = cur_sel_r;
            end
        endcase

        busy_s = (state_s == ST_SWITCH);
    end

    // State, counter and output registers; reset drops sel to clk1 at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            sel_r     <= 1'b0;
            cur_sel_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            sel_r     <= sel_s;
            cur_sel_r <= cur_sel_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            err_r     <= err_s;
        end
    end

    // Drive output ports from their registers.
    always_comb begin
        sel     = sel_r;
        cur_sel = cur_sel_r;
        busy    = busy_r;
        done    = done_r;
        err     = err_r;
    end

endmodule : glitchless_mux_ctrl

// File: tb/tb_glitchless_mux_ctrl.sv
// -----------------------------------------------------------------------------
// tb_glitchless_mux_ctrl
//
// Directed testbench for glitchless_mux_ctrl with SETTLE_CYCLES = 16.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_glitchless_mux_ctrl;

    localparam int SETTLE = 16;

    logic       clk;
    logic       rst;
    logic [1:0] tgt_alive;
    logic       sel;
    logic       cur_sel;
    logic       busy;
    logic       done;
    logic       err;

    int err_cnt;
    int chk_cnt;

    glitchless_mux_ctrl_if req_if ();

    glitchless_mux_ctrl #(
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_if    (req_if),
        .tgt_alive (tgt_alive),
        .sel       (sel),
        .cur_sel   (cur_sel),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        if (got !== exp) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request that is accepted at the next edge (controller idle).
    task automatic request(input logic rsel);
        req_if.req_valid = 1'b1;
        req_if.req_sel   = rsel;
        tick();
        req_if.req_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic seen_done;

        err_cnt          = 0;
        chk_cnt          = 0;
        rst              = 1'b1;
        tgt_alive        = 2'b11;
        req_if.req_valid = 1'b0;
        req_if.req_sel   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // 1. Reset state
        check_eq("rst_sel",     {31'd0, sel},              32'd0);
        check_eq("rst_cur_sel", {31'd0, cur_sel},          32'd0);
        check_eq("rst_ready",   {31'd0, req_if.req_ready}, 32'd1);
        check_eq("rst_busy",    {31'd0, busy},             32'd0);
        check_eq("rst_done",    {31'd0, done},             32'd0);
        check_eq("rst_err",     {31'd0, err},              32'd0);

        // 3a. No-op: request clk1 while on clk1
        request(1'b0);
        check_eq("noop_done",  {31'd0, done}, 32'd1);
        check_eq("noop_err",   {31'd0, err},  32'd0);
        check_eq("noop_busy",  {31'd0, busy}, 32'd0);
        check_eq("noop_sel",   {31'd0, sel},  32'd0);
        tick();
        check_eq("noop_done_end", {31'd0, done}, 32'd0);

        // 3b. Reject: clk2 reported dead
        tgt_alive = 2'b01;
        request(1'b1);
        check_eq("rej_err",   {31'd0, err},  32'd1);
        check_eq("rej_done",  {31'd0, done}, 32'd0);
        check_eq("rej_sel",   {31'd0, sel},  32'd0);
        check_eq("rej_busy",  {31'd0, busy}, 32'd0);
        tick();
        check_eq("rej_err_end", {31'd0, err}, 32'd0);

        // 4. Abort: clk2 dies at t0+5
        tgt_alive = 2'b11;
        request(1'b1);
        check_eq("abt_sel_t0", {31'd0, sel}, 32'd1);
        repeat (4) tick();
        check_eq("abt_busy_t4", {31'd0, busy}, 32'd1);
        tgt_alive = 2'b01;
        tick();
        check_eq("abt_sel",     {31'd0, sel},              32'd0);
        check_eq("abt_err",     {31'd0, err},              32'd1);
        check_eq("abt_done",    {31'd0, done},             32'd0);
        check_eq("abt_busy",    {31'd0, busy},             32'd0);
        check_eq("abt_cur_sel", {31'd0, cur_sel},          32'd0);
        check_eq("abt_ready",   {31'd0, req_if.req_ready}, 32'd1);
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        check_eq("abt_no_done", {31'd0, seen_done}, 32'd0);
        check_eq("abt_err_end", {31'd0, err},       32'd0);

        // 2 + 5. Full switch to clk2 with req_valid held for a return to clk1
        tgt_alive        = 2'b11;
        req_if.req_valid = 1'b1;
        req_if.req_sel   = 1'b1;
        tick();                                  // t0
        req_if.req_sel = 1'b0;                   // next request, kept valid
        check_eq("sw_sel_t0",   {31'd0, sel},              32'd1);
        check_eq("sw_busy_t0",  {31'd0, busy},             32'd1);
        check_eq("sw_ready_t0", {31'd0, req_if.req_ready}, 32'd0);
        n = 1;
        for (int i = 1; i < SETTLE; i++) begin
            tick();
            if (busy) n = n + 1;
        end
        check_eq("sw_busy_cycles", n, SETTLE);
        check_eq("sw_sel_hold",    {31'd0, sel},  32'd1);
        check_eq("sw_done_early",  {31'd0, done}, 32'd0);
        tick();                                  // t0+16
        check_eq("sw_done",     {31'd0, done},             32'd1);
        check_eq("sw_busy_end", {31'd0, busy},             32'd0);
        check_eq("sw_cur_sel",  {31'd0, cur_sel},          32'd1);
        check_eq("sw_ready",    {31'd0, req_if.req_ready}, 32'd1);
        check_eq("sw_err",      {31'd0, err},              32'd0);
        tick();                                  // second request accepted here
        req_if.req_valid = 1'b0;
        check_eq("b2b_sel",  {31'd0, sel},  32'd0);
        check_eq("b2b_busy", {31'd0, busy}, 32'd1);
        check_eq("b2b_done", {31'd0, done}, 32'd0);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n = n + 1;
        end
        check_eq("b2b_latency", n,                 SETTLE);
        check_eq("b2b_cur_sel", {31'd0, cur_sel},  32'd0);
        check_eq("b2b_busy_end", {31'd0, busy},    32'd0);

        // 6. Asynchronous reset 8 cycles into a switch to clk2
        tick();
        request(1'b1);
        repeat (8) tick();
        check_eq("ar_sel_before", {31'd0, sel}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_sel",     {31'd0, sel},              32'd0);
        check_eq("ar_busy",    {31'd0, busy},             32'd0);
        check_eq("ar_cur_sel", {31'd0, cur_sel},          32'd0);
        check_eq("ar_ready",   {31'd0, req_if.req_ready}, 32'd1);
        tick();
        #2;
        rst = 1'b0;
        tick();
        request(1'b1);
        check_eq("ar_new_sel",  {31'd0, sel},  32'd1);
        check_eq("ar_new_busy", {31'd0, busy}, 32'd1);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n = n + 1;
        end
        check_eq("ar_new_latency", n,                SETTLE);
        check_eq("ar_new_cur_sel", {31'd0, cur_sel}, 32'd1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_glitchless_mux_ctrl

// File: doc/glitchless_mux_ctrl.md
Name: glitchless_mux_ctrl

Overview:
Switch sequencer that drives the select input of the 2:1 glitch-free clock mux and reports handover completion.
- Runs on an always-on reference clock.
- Accepts switch requests over a valid/ready handshake and rejects switches to a clock flagged as dead.
- After changing select, holds off for a programmable settle window that covers the mux's two-stage synchronisers in both clock domains, then pulses done.

Parameters:
- SETTLE_CYCLES, 16: clk cycles between a select change and done. Legal range >= 2. Must cover 2 x (2 sync stages x slowest mux clock period), expressed in clk periods.
- CNT_W, $clog2(SETTLE_CYCLES+1): settle counter width. Derived; not overridden.

Ports:
- clk  input  1  reference clock; always running
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  switch request valid
- req_sel  input  1  requested clock: 0 = clk1, 1 = clk2
- req_ready  output  1  controller can accept a request
- tgt_alive  input  2  per-clock liveness; bit0 = clk1, bit1 = clk2; already synchronous to clk
- sel  output  1  select to the mux
- cur_sel  output  1  last completed selection
- busy  output  1  switch in progress
- done  output  1  one-cycle pulse: switch completed or no-op accepted
- err  output  1  one-cycle pulse: request rejected or switch aborted

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high.
- Reset values: sel=0, cur_sel=0, busy=0, done=0, err=0, state=IDLE, cnt=0. req_ready=1 (combinational, state==IDLE).
- Asynchronous reset mid-switch forces sel=0 immediately. This is safe because the mux handles the reversal glitch-free.
- States:
  - IDLE: req_ready=1.
  - SWITCH: req_ready=0, busy=1.
- Handshake: a request is accepted at a rising edge where req_valid && req_ready. req_valid while busy is ignored; the requester holds it until accepted. req_sel is sampled only at acceptance.
- IDLE, accept at edge t0. Cases are priority-ordered:
  1. req_sel==cur_sel: no-op. done=1 for the cycle after t0; stay IDLE; sel unchanged.
  2. tgt_alive[req_sel]==0: reject. err=1 for the cycle after t0; stay IDLE; sel and cur_sel unchanged.
  3. Otherwise: after t0, sel=req_sel, cnt=SETTLE_CYCLES-1, state=SWITCH, busy=1.
- SWITCH, each edge, in priority order:
  1. tgt_alive[sel]==0: abort. sel<=cur_sel, err=1 one cycle, go to IDLE, cur_sel unchanged.
  2. cnt==0: cur_sel<=sel, done=1 one cycle, go to IDLE.
  3. Otherwise: cnt<=cnt-1.
- Latency:
  - Full switch: busy high for exactly SETTLE_CYCLES cycles (after t0 through after t0+SETTLE_CYCLES-1). done high the cycle after t0+SETTLE_CYCLES.
  - No-op and reject: 1 cycle.
- done and err are never high in the same cycle. Each is high for exactly one cycle per event.
- Back-to-back: in the cycle done or err is high, state is IDLE and req_ready=1. A new request can be accepted at the next edge.
- Liveness of the current (source) clock is not checked. If the source is dead, the mux cannot release it. The switch still completes after the settle window; recovery is via rst.
- Counter never wraps: it is loaded only on accept and stops at 0.

Test Plan:
1. Reset release, no requests -> sel=0, cur_sel=0, req_ready=1, busy=0, done=0, err=0.
2. SETTLE_CYCLES=16, tgt_alive=2'b11, req_sel=1 accepted at t0 -> sel=1 after t0; busy high 16 cycles; done pulse after t0+16; cur_sel=1; req_ready=1 again.
3. cur_sel=0, req_sel=0 -> done pulse after t0, sel unchanged, busy never asserted. tgt_alive=2'b01, req_sel=1 -> err pulse after t0, sel stays 0.
4. Switch to clk2 in progress; drop tgt_alive[1] 5 cycles after t0 -> sel returns to 0 at that edge, err pulse, cur_sel=0, no done pulse.
5. req_valid held high during a switch -> request not accepted until done cycle; second switch (back to clk1) starts at next edge and completes 16 cycles later.
6. Assert rst 8 cycles into a switch to clk2 -> sel=0, busy=0, cur_sel=0 immediately, without waiting for a clk edge; after release, a new request is accepted normally.
